// File: rtl/idma_reg64_launcher_pkg.sv
// Shared types, FSM states and register map of the 64-bit iDMA register launcher.
// IDMA_REG64_LAUNCHER_WAIT_DONE_EN adds the DONE polling states.
package idma_reg64_launcher_pkg;

  typedef struct packed {
    logic [63:0] src_addr;
    logic [63:0] dst_addr;
    logic [63:0] length;
    logic        decouple;
    logic        deburst;
  } job_t;

  // Default register_interface flavour with 64-bit data.
  typedef struct packed {
    logic [63:0] addr;
    logic        write;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        valid;
  } reg64_req_t;

  typedef struct packed {
    logic [63:0] rdata;
    logic        error;
    logic        ready;
  } reg64_rsp_t;

  localparam logic [63:0] RegOffSrc    = 64'h00;
  localparam logic [63:0] RegOffDst    = 64'h08;
  localparam logic [63:0] RegOffLen    = 64'h10;
  localparam logic [63:0] RegOffConf   = 64'h18;
  localparam logic [63:0] RegOffStatus = 64'h20;
  localparam logic [63:0] RegOffNextId = 64'h28;
  localparam logic [63:0] RegOffDone   = 64'h30;

  localparam int unsigned ConfDecoupleBit = 0;
  localparam int unsigned ConfDeburstBit  = 1;
  localparam logic [7:0]  WstrbAll        = 8'hFF;

  typedef enum logic [3:0] {
    StIdle,
    StWrSrc,
    StWrDst,
    StWrLen,
    StWrConf,
    StRdId,
    StResp
`ifdef IDMA_REG64_LAUNCHER_WAIT_DONE_EN
    ,
    StPollWait,
    StPollRd
`endif
  } state_e;

  function automatic logic [63:0] conf_word(input logic decouple, input logic deburst);
    logic [63:0] w;
    w                  = '0;
    w[ConfDecoupleBit] = decouple;
    w[ConfDeburstBit]  = deburst;
    return w;
  endfunction

  // Wrap-safe "done has caught up with id": sign of the 64-bit difference.
  function automatic logic done_reached(input logic [63:0] done, input logic [63:0] id);
    logic [63:0] diff;
    diff = done - id;
    return ~diff[63];
  endfunction

endpackage

// File: rtl/idma_reg64_launcher.sv
// Programs a 64-bit iDMA register frontend for one job at a time and returns the transfer ID.
// Optional IDMA_REG64_LAUNCHER_WAIT_DONE_EN: poll DONE until the transfer has completed.
module idma_reg64_launcher
  import idma_reg64_launcher_pkg::*;
#(
  parameter logic [63:0] RegBase   = 64'h0,
  parameter int unsigned PollGap   = 4,
  parameter type         reg_req_t = reg64_req_t,
  parameter type         reg_rsp_t = reg64_rsp_t
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  job_t        job_i,
  input  logic        job_valid_i,
  output logic        job_ready_o,
  output logic [63:0] id_o,
  output logic        id_err_o,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output reg_req_t    reg_req_o,
  input  reg_rsp_t    reg_rsp_i,
  output logic        busy_o
);

  if (PollGap == 0) begin : gen_bad_poll_gap
    $error("PollGap must be at least 1");
  end

  state_e      state_q, state_d;
  job_t        job_q, job_d;
  logic [63:0] id_q, id_d;
  logic        id_err_q, id_err_d;
  logic        id_valid_q, id_valid_d;
  logic        job_ready_q, job_ready_d;
  reg_req_t    req;
  logic        beat_done, beat_err;

`ifdef IDMA_REG64_LAUNCHER_WAIT_DONE_EN
  localparam int unsigned GapW = (PollGap > 1) ? $clog2(PollGap + 1) : 1;
  logic [GapW-1:0] gap_q, gap_d;
`endif

  function automatic reg_req_t make_req(input logic [63:0] off, input logic write,
                                        input logic [63:0] wdata);
    reg_req_t r;
    r       = '0;
    r.addr  = RegBase + off;
    r.write = write;
    r.wdata = wdata;
    r.wstrb = write ? WstrbAll : 8'h00;
    r.valid = 1'b1;
    return r;
  endfunction

  // Bus request is a pure decode of registered state, so it is stable while a beat waits.
  always_comb begin
    req = '0;
    unique case (state_q)
      StWrSrc:  req = make_req(RegOffSrc, 1'b1, job_q.src_addr);
      StWrDst:  req = make_req(RegOffDst, 1'b1, job_q.dst_addr);
      StWrLen:  req = make_req(RegOffLen, 1'b1, job_q.length);
      StWrConf: req = make_req(RegOffConf, 1'b1, conf_word(job_q.decouple, job_q.deburst));
      StRdId:   req = make_req(RegOffNextId, 1'b0, 64'h0);
`ifdef IDMA_REG64_LAUNCHER_WAIT_DONE_EN
      StPollRd: req = make_req(RegOffDone, 1'b0, 64'h0);
`endif
      default:  req = '0;
    endcase
  end

  assign beat_done = req.valid && reg_rsp_i.ready;
  assign beat_err  = beat_done && reg_rsp_i.error;

  always_comb begin
    state_d     = state_q;
    job_d       = job_q;
    id_d        = id_q;
    id_err_d    = id_err_q;
    id_valid_d  = id_valid_q;
    job_ready_d = job_ready_q;
`ifdef IDMA_REG64_LAUNCHER_WAIT_DONE_EN
    gap_d       = gap_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (job_valid_i && job_ready_q) begin
          job_d       = job_i;
          job_ready_d = 1'b0;
          if (job_i.length == 64'h0) begin
            // The frontend would hand back ID 0, so skip the bus entirely.
            state_d    = StResp;
            id_d       = 64'h0;
            id_err_d   = 1'b1;
            id_valid_d = 1'b1;
          end else begin
            state_d = StWrSrc;
          end
        end
      end
      StWrSrc:  if (beat_done) state_d = StWrDst;
      StWrDst:  if (beat_done) state_d = StWrLen;
      StWrLen:  if (beat_done) state_d = StWrConf;
      StWrConf: if (beat_done) state_d = StRdId;
      StRdId: begin
        if (beat_done) begin
          id_d = reg_rsp_i.rdata;
`ifdef IDMA_REG64_LAUNCHER_WAIT_DONE_EN
          state_d = StPollWait;
          gap_d   = GapW'(PollGap);
`else
          state_d    = StResp;
          id_err_d   = 1'b0;
          id_valid_d = 1'b1;
`endif
        end
      end
`ifdef IDMA_REG64_LAUNCHER_WAIT_DONE_EN
      StPollWait: begin
        if (gap_q <= GapW'(1)) begin
          state_d = StPollRd;
        end else begin
          gap_d = gap_q - GapW'(1);
        end
      end
      StPollRd: begin
        if (beat_done) begin
          if (done_reached(reg_rsp_i.rdata, id_q)) begin
            state_d    = StResp;
            id_err_d   = 1'b0;
            id_valid_d = 1'b1;
          end else begin
            state_d = StPollWait;
            gap_d   = GapW'(PollGap);
          end
        end
      end
`endif
      StResp: begin
        if (id_ready_i) begin
          state_d     = StIdle;
          id_valid_d  = 1'b0;
          job_ready_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // A bus error on any beat abandons the rest of the sequence.
    if (beat_err) begin
      state_d    = StResp;
      id_d       = 64'h0;
      id_err_d   = 1'b1;
      id_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      job_q       <= '0;
      id_q        <= 64'h0;
      id_err_q    <= 1'b0;
      id_valid_q  <= 1'b0;
      job_ready_q <= 1'b1;
`ifdef IDMA_REG64_LAUNCHER_WAIT_DONE_EN
      gap_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      job_q       <= job_d;
      id_q        <= id_d;
      id_err_q    <= id_err_d;
      id_valid_q  <= id_valid_d;
      job_ready_q <= job_ready_d;
`ifdef IDMA_REG64_LAUNCHER_WAIT_DONE_EN
      gap_q       <= gap_d;
`endif
    end
  end

  assign reg_req_o   = req;
  assign job_ready_o = job_ready_q;
  assign id_o        = id_q;
  assign id_err_o    = id_err_q;
  assign id_valid_o  = id_valid_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_idma_reg64_launcher.sv
// Randomized bench for idma_reg64_launcher with a register-slave model and a job-level reference.
module tb_idma_reg64_launcher;
  import idma_reg64_launcher_pkg::*;

  localparam logic [63:0] Base = 64'h0000_0000_4000_0000;
  localparam int unsigned Gap  = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  job_t        job;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [63:0] id;
  logic        id_err, id_valid;
  logic        id_ready = 1'b0;
  reg64_req_t  req;
  reg64_rsp_t  rsp;
  logic        busy;

  always #5 clk_i = ~clk_i;

  idma_reg64_launcher #(
    .RegBase  (Base),
    .PollGap  (Gap),
    .reg_req_t(reg64_req_t),
    .reg_rsp_t(reg64_rsp_t)
  ) u_dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .job_i      (job),
    .job_valid_i(job_valid),
    .job_ready_o(job_ready),
    .id_o       (id),
    .id_err_o   (id_err),
    .id_valid_o (id_valid),
    .id_ready_i (id_ready),
    .reg_req_o  (req),
    .reg_rsp_i  (rsp),
    .busy_o     (busy)
  );

  typedef struct {
    logic [63:0] addr;
    logic        write;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    int unsigned gap;
  } beat_t;

  // Slave model configuration
  logic [63:0] slv_next_id = '0;
  logic [63:0] slv_err_off = '0;
  logic        slv_err_en = 1'b0;
  logic [63:0] slv_stall_off = '0;
  int unsigned slv_stall_n = 0;
  logic [63:0] done_vals[4];
  int unsigned done_n = 0, done_idx = 0;
  logic        slv_rdy = 1'b0;

  // Monitor state
  beat_t       beats[$];
  beat_t       exp_q[$];
  reg64_req_t  prev;
  logic        have_prev = 1'b0, pop_pend = 1'b0;
  int unsigned wait_cnt = 0, idle = 0, unstable = 0, excl_bad = 0;

  int unsigned n_checks = 0, n_errors = 0;

  logic        rdy_w, err_w;
  logic [63:0] rdata_w;
  assign rdy_w   = req.valid && slv_rdy;
  assign err_w   = rdy_w && slv_err_en && (req.addr == Base + slv_err_off);
  assign rdata_w = (req.addr == Base + RegOffDone && done_idx < done_n) ?
                   done_vals[done_idx[1:0]] : slv_next_id;
  assign rsp     = {rdata_w, err_w, rdy_w};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Decides ready for the coming edge and records completed beats.
  always @(negedge clk_i) begin
    if (pop_pend) begin
      done_idx++;
      pop_pend = 1'b0;
    end
    if (id_valid && job_ready) excl_bad++;
    if (!rst_ni) begin
      wait_cnt = 0; have_prev = 1'b0; idle = 0; slv_rdy = 1'b0;
    end else if (req.valid) begin
      if (have_prev && (req.addr !== prev.addr || req.write !== prev.write ||
                        req.wdata !== prev.wdata)) unstable++;
      slv_rdy = (req.addr != Base + slv_stall_off) || (wait_cnt >= slv_stall_n);
      if (slv_rdy) begin
        beats.push_back('{req.addr, req.write, req.wdata, req.wstrb, idle});
        if (req.addr == Base + RegOffDone && done_idx < done_n) pop_pend = 1'b1;
        wait_cnt = 0; have_prev = 1'b0; idle = 0;
      end else begin
        wait_cnt++; prev = req; have_prev = 1'b1;
      end
    end else begin
      slv_rdy = 1'b0; have_prev = 1'b0; wait_cnt = 0; idle++;
    end
  end

  function automatic logic [63:0] beat_off(input int i);
    case (i)
      0: return RegOffSrc;
      1: return RegOffDst;
      2: return RegOffLen;
      3: return RegOffConf;
      default: return RegOffNextId;
    endcase
  endfunction

  logic [63:0] exp_id;
  logic        exp_err;
  int unsigned exp_npolls;

  // Reference: list of register accesses and the result a job should produce.
  task automatic build_expect(input job_t j, input logic [63:0] nid, input int err_beat);
    logic [63:0] wd[5];
    logic        fin;
    exp_q.delete();
    exp_err = 1'b0; exp_id = nid; exp_npolls = 0;
    wd[0] = j.src_addr; wd[1] = j.dst_addr; wd[2] = j.length;
    wd[3] = 64'(j.decouple) + 64'(j.deburst) * 2; wd[4] = 64'h0;
    if (j.length == 64'h0) begin
      exp_err = 1'b1; exp_id = 64'h0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        exp_q.push_back('{Base + beat_off(i), i < 4, wd[i], 8'hFF, 0});
        if (i == err_beat) break;
      end
      if (err_beat >= 0) begin
        exp_err = 1'b1; exp_id = 64'h0;
      end
`ifdef IDMA_REG64_LAUNCHER_WAIT_DONE_EN
      else begin
        fin = 1'b0;
        for (int i = 0; i < int'(done_n) && !fin; i++) begin
          exp_npolls++;
          exp_q.push_back('{Base + RegOffDone, 1'b0, 64'h0, 8'h00, 0});
          if ($signed(done_vals[i] - nid) >= 0) fin = 1'b1;
        end
        if (!fin) begin
          exp_npolls++;
          exp_q.push_back('{Base + RegOffDone, 1'b0, 64'h0, 8'h00, 0});
        end
      end
`endif
    end
  endtask

  task automatic run_job(input job_t j, input logic [63:0] nid, input int err_beat,
                         input int stall_beat, input int stall_n, input int hold);
    int n, lat, exp_lat, hold_bad;
    slv_next_id = nid;
    slv_err_en = (err_beat >= 0);
    slv_err_off = beat_off(err_beat);
    slv_stall_off = beat_off(stall_beat);
    slv_stall_n = stall_n;
    done_idx = 0;
    build_expect(j, nid, err_beat);
    exp_lat = exp_q.size() + exp_npolls * Gap;
    if (stall_beat < exp_q.size()) exp_lat += stall_n;
    beats.delete();
    n = 0;
    while (!job_ready && n < 20) begin @(negedge clk_i); n++; end
    check("job_ready_idle", job_ready, 1'b1);
    job = j; job_valid = 1'b1;
    @(negedge clk_i);
    job_valid = 1'b0;
    lat = 0;
    while (!id_valid && lat < 400) begin @(negedge clk_i); lat++; end
    check("latency", 64'(lat), 64'(exp_lat));
    check("id", id, exp_id);
    check("id_err", id_err, exp_err);
    check("job_ready_resp", job_ready, 1'b0);
    check("busy_resp", busy, 1'b1);
    check("nbeats", 64'(beats.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < beats.size(); i++) begin
      check("beat_addr", beats[i].addr, exp_q[i].addr);
      check("beat_write", beats[i].write, exp_q[i].write);
      if (exp_q[i].write) begin
        check("beat_wdata", beats[i].wdata, exp_q[i].wdata);
        check("beat_wstrb", beats[i].wstrb, exp_q[i].wstrb);
      end
`ifdef IDMA_REG64_LAUNCHER_WAIT_DONE_EN
      if (i >= 5) check("poll_gap", beats[i].gap >= Gap, 1'b1);
`endif
    end
    hold_bad = 0;
    job_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      if (!id_valid || job_ready) hold_bad++;
    end
    check("hold_result", 64'(hold_bad), 64'h0);
    job_valid = 1'b0; id_ready = 1'b1;
    @(negedge clk_i);
    id_ready = 1'b0;
    check("consumed_valid", id_valid, 1'b0);
    check("consumed_ready", job_ready, 1'b1);
    check("consumed_busy", busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    job_t j;
    int   n, eb;
    job = '0;
    repeat (3) @(negedge clk_i);
    check("rst_job_ready", job_ready, 1'b1);
    check("rst_id_valid", id_valid, 1'b0);
    check("rst_id", id, 64'h0);
    check("rst_id_err", id_err, 1'b0);
    check("rst_req_zero", req == '0, 1'b1);
    check("rst_busy", busy, 1'b0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    j = '{src_addr: 64'h1000, dst_addr: 64'h2000, length: 64'h40, decouple: 1'b1, deburst: 1'b0};
    run_job(j, 64'd7, -1, 0, 0, 0);
    run_job(j, 64'd9, -1, 4, 10, 0);
    run_job(j, 64'd11, 1, 0, 0, 1);
    j.length = 64'h0;
    run_job(j, 64'd12, -1, 0, 0, 0);
    j.length = 64'h80; j.deburst = 1'b1;
    run_job(j, 64'd13, -1, 2, 3, 8);

    for (int k = 0; k < 40; k++) begin
      j.src_addr = {$urandom, $urandom};
      j.dst_addr = {$urandom, $urandom};
      j.length   = ($urandom_range(0, 4) == 0) ? 64'h0 : {$urandom, $urandom};
      j.decouple = 1'($urandom_range(0, 1));
      j.deburst  = 1'($urandom_range(0, 1));
      eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_job(j, {$urandom, $urandom}, eb, int'($urandom_range(0, 4)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

`ifdef IDMA_REG64_LAUNCHER_WAIT_DONE_EN
    done_vals[0] = 64'd3; done_vals[1] = 64'd4; done_vals[2] = 64'd5; done_n = 3;
    run_job(j, 64'd5, -1, 0, 0, 0);
    check("poll_reads", 64'(exp_npolls), 64'd3);
    done_vals[0] = 64'hFFFF_FFFF_FFFF_FFFD; done_vals[1] = 64'h1; done_n = 2;
    run_job(j, 64'hFFFF_FFFF_FFFF_FFFE, -1, 0, 0, 0);
    done_n = 0;
`endif

    // Reset while the LEN write is stalled on the bus.
    slv_err_en = 1'b0; slv_stall_off = RegOffLen; slv_stall_n = 30;
    j.length = 64'h100;
    n = 0;
    while (!job_ready && n < 20) begin @(negedge clk_i); n++; end
    job = j; job_valid = 1'b1;
    @(negedge clk_i);
    job_valid = 1'b0;
    n = 0;
    while (!(req.valid && req.addr == Base + RegOffLen) && n < 20) begin
      @(negedge clk_i); n++;
    end
    check("reach_len", req.addr, Base + RegOffLen);
    #1 rst_ni = 1'b0;
    #1;
    check("mid_rst_req_valid", req.valid, 1'b0);
    check("mid_rst_req_zero", req == '0, 1'b1);
    check("mid_rst_job_ready", job_ready, 1'b1);
    check("mid_rst_id_valid", id_valid, 1'b0);
    check("mid_rst_id", id, 64'h0);
    check("mid_rst_id_err", id_err, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    beats.delete();
    repeat (6) @(negedge clk_i);
    check("post_rst_beats", 64'(beats.size()), 64'h0);
    check("post_rst_ready", job_ready, 1'b1);
    slv_stall_n = 0;

    check("req_stable", 64'(unstable), 64'h0);
    check("valid_ready_excl", 64'(excl_bad), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
